// File: rtl/id_ex_forward_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_forward_stage
// Brief   : ID/EX pipeline register with EX-stage operand forwarding muxes
//           and load-use hazard detection for a 5-stage MIPS pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_forward_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [ALUOP_W-1:0]    id_alu_op,
    input  logic [4:0]            id_ctrl,
    input  logic                  id_mem_to_reg,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [DATA_W-1:0]     exm_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [ALUOP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]     store_data,
    output logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  load_use_hazard
);

    // Bit positions inside the control bundle {alu_src, reg_dst, reg_write, mem_read, mem_write}
    localparam int C_ALU_SRC   = 4;
    localparam int C_REG_DST   = 3;
    localparam int C_REG_WRITE = 2;
    localparam int C_MEM_READ  = 1;
    localparam int C_MEM_WRITE = 0;

    logic [DATA_W-1:0]     r_rd1;
    logic [DATA_W-1:0]     r_rd2;
    logic [DATA_W-1:0]     r_imm;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [ALUOP_W-1:0]    r_alu_op;
    logic [4:0]            r_ctrl;
    logic                  r_mem_to_reg;

    logic                  w_exm_hit_rs;
    logic                  w_exm_hit_rt;
    logic                  w_wb_hit_rs;
    logic                  w_wb_hit_rt;
    logic [DATA_W-1:0]     w_fwd_rs;
    logic [DATA_W-1:0]     w_fwd_rt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_alu_op     <= '0;
            r_ctrl       <= '0;
            r_mem_to_reg <= 1'b0;
        end else if (flush) begin
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_alu_op     <= '0;
            r_ctrl       <= '0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            r_rd1        <= id_rd1;
            r_rd2        <= id_rd2;
            r_imm        <= id_imm;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rd         <= id_rd;
            r_alu_op     <= id_alu_op;
            r_ctrl       <= id_ctrl;
            r_mem_to_reg <= id_mem_to_reg;
        end
    end

    // $0 is hardwired to zero, so a stage claiming to write it must never forward.
    assign w_exm_hit_rs = exm_reg_write && (exm_rd != '0) && (exm_rd == r_rs);
    assign w_exm_hit_rt = exm_reg_write && (exm_rd != '0) && (exm_rd == r_rt);
    assign w_wb_hit_rs  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == r_rs);
    assign w_wb_hit_rt  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == r_rt);

    // EX/MEM holds the younger result, so it takes priority over MEM/WB.
    always_comb begin
        w_fwd_rs = r_rd1;
        if (w_exm_hit_rs) begin
            w_fwd_rs = exm_result;
        end else if (w_wb_hit_rs) begin
            w_fwd_rs = wb_data;
        end
    end

    always_comb begin
        w_fwd_rt = r_rd2;
        if (w_exm_hit_rt) begin
            w_fwd_rt = exm_result;
        end else if (w_wb_hit_rt) begin
            w_fwd_rt = wb_data;
        end
    end

    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_ctrl[C_ALU_SRC] ? r_imm : w_fwd_rt;
    assign store_data    = w_fwd_rt;
    assign alu_op        = r_alu_op;
    assign ex_write_reg  = r_ctrl[C_REG_DST] ? r_rd : r_rt;
    assign ex_reg_write  = r_ctrl[C_REG_WRITE];
    assign ex_mem_read   = r_ctrl[C_MEM_READ];
    assign ex_mem_write  = r_ctrl[C_MEM_WRITE];
    assign ex_mem_to_reg = r_mem_to_reg;

    // A load in EX cannot forward in time to a dependent instruction in ID.
    assign load_use_hazard = r_ctrl[C_MEM_READ] && (r_rt != '0) &&
                             ((r_rt == id_rs) || (r_rt == id_rt));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_forward_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_forward_stage
// Brief   : Scoreboard testbench for id_ex_forward_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_forward_stage;

    localparam int C_SEL_A     = 0;
    localparam int C_SEL_B     = 1;
    localparam int C_SEL_OP    = 2;
    localparam int C_SEL_SD    = 3;
    localparam int C_SEL_WREG  = 4;
    localparam int C_SEL_RW    = 5;
    localparam int C_SEL_MR    = 6;
    localparam int C_SEL_MW    = 7;
    localparam int C_SEL_M2R   = 8;
    localparam int C_SEL_HAZ   = 9;
    localparam int C_SEL_ALLZ  = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk, rst, stall, flush;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_alu_op;
    logic [4:0]  id_ctrl;
    logic        id_mem_to_reg;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] alu_a, alu_b, store_data;
    logic [2:0]  alu_op;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_hazard;

    exp_t q[$];
    event chk_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    id_ex_forward_stage #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
        .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            C_SEL_A:    return alu_a;
            C_SEL_B:    return alu_b;
            C_SEL_OP:   return {29'b0, alu_op};
            C_SEL_SD:   return store_data;
            C_SEL_WREG: return {27'b0, ex_write_reg};
            C_SEL_RW:   return {31'b0, ex_reg_write};
            C_SEL_MR:   return {31'b0, ex_mem_read};
            C_SEL_MW:   return {31'b0, ex_mem_write};
            C_SEL_M2R:  return {31'b0, ex_mem_to_reg};
            C_SEL_HAZ:  return {31'b0, load_use_hazard};
            C_SEL_ALLZ: return {31'b0, |{alu_a, alu_b, alu_op, store_data, ex_write_reg,
                                         ex_reg_write, ex_mem_read, ex_mem_write,
                                         ex_mem_to_reg, load_use_hazard}};
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current observation point.
    initial begin
        exp_t it;
        logic [31:0] act;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                it  = q.pop_front();
                act = actual(it.sel);
                n_checks++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_v(input string nm, input int sel, input logic [31:0] e);
        exp_t it;
        it.name = nm;
        it.sel  = sel;
        it.exp  = e;
        q.push_back(it);
    endtask

    task automatic fire();
        -> chk_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_id(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [2:0] op, input logic [4:0] ctrl, input logic m2r);
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_alu_op = op; id_ctrl = ctrl; id_mem_to_reg = m2r;
    endtask

    task automatic fwd(input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
                       input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
        exm_reg_write = exw; exm_rd = exrd; exm_result = exres;
        wb_reg_write = wbw; wb_rd = wbrd; wb_data = wbd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        load_id($urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 5'($urandom), 1'($urandom));
        fwd(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom);
        tick();
        expect_v("reset_all_zero", C_SEL_ALLZ, 32'd0);
        fire();

        // add $3, $1, $2 with rd1=5, rd2=7
        @(negedge clk);
        rst = 1'b0;
        load_id(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'b010, 5'b01100, 1'b0);
        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        expect_v("add_alu_a", C_SEL_A, 32'd5);
        expect_v("add_alu_b", C_SEL_B, 32'd7);
        expect_v("add_alu_op", C_SEL_OP, 32'd2);
        expect_v("add_wreg", C_SEL_WREG, 32'd3);
        expect_v("add_reg_write", C_SEL_RW, 32'd1);
        fire();

        // Forwarding priority on rs=3
        @(negedge clk);
        load_id(32'h99, 32'd7, 32'd0, 5'd3, 5'd2, 5'd3, 3'b010, 5'b01100, 1'b0);
        fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        tick();
        expect_v("fwd_exm_wins", C_SEL_A, 32'h10);
        fire();
        exm_reg_write = 1'b0;
        #1;
        expect_v("fwd_wb_only", C_SEL_A, 32'h20);
        fire();
        exm_reg_write = 1'b1; exm_rd = 5'd4;
        #1;
        expect_v("fwd_exm_other_reg", C_SEL_A, 32'h20);
        fire();
        exm_reg_write = 1'b0; wb_reg_write = 1'b0;
        #1;
        expect_v("fwd_none_rd1", C_SEL_A, 32'h99);
        fire();

        // $0 never forwarded
        @(negedge clk);
        load_id(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 3'b010, 5'b01100, 1'b0);
        fwd(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1234);
        tick();
        expect_v("zero_reg_alu_a", C_SEL_A, 32'd0);
        expect_v("zero_reg_store", C_SEL_SD, 32'd0);
        fire();

        // lw $4, 8($1) in EX: load-use detection
        @(negedge clk);
        load_id(32'h100, 32'd0, 32'd8, 5'd1, 5'd4, 5'd9, 3'b010, 5'b10110, 1'b1);
        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        expect_v("lw_alu_b_imm", C_SEL_B, 32'd8);
        expect_v("lw_wreg_rt", C_SEL_WREG, 32'd4);
        expect_v("lw_mem_read", C_SEL_MR, 32'd1);
        expect_v("lw_mem_to_reg", C_SEL_M2R, 32'd1);
        fire();
        id_rs = 5'd4; id_rt = 5'd6;
        #1;
        expect_v("hazard_rs_match", C_SEL_HAZ, 32'd1);
        fire();
        id_rs = 5'd5; id_rt = 5'd5;
        #1;
        expect_v("hazard_no_match", C_SEL_HAZ, 32'd0);
        fire();
        id_rt = 5'd4;
        #1;
        expect_v("hazard_rt_match", C_SEL_HAZ, 32'd1);
        fire();
        @(negedge clk);
        load_id(32'd0, 32'd0, 32'd0, 5'd1, 5'd0, 5'd0, 3'b010, 5'b10110, 1'b1);
        tick();
        id_rs = 5'd0; id_rt = 5'd0;
        #1;
        expect_v("hazard_rt_zero", C_SEL_HAZ, 32'd0);
        fire();

        // Stall holds the register for three cycles
        @(negedge clk);
        load_id(32'h11, 32'h22, 32'd0, 5'd7, 5'd8, 5'd9, 3'b011, 5'b01101, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            load_id($urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                    3'($urandom), 5'($urandom), 1'($urandom));
            tick();
            expect_v("stall_alu_a", C_SEL_A, 32'h11);
            expect_v("stall_alu_b", C_SEL_B, 32'h22);
            expect_v("stall_alu_op", C_SEL_OP, 32'd3);
            expect_v("stall_wreg", C_SEL_WREG, 32'd9);
            expect_v("stall_mem_write", C_SEL_MW, 32'd1);
            fire();
        end
        @(negedge clk);
        flush = 1'b1;
        tick();
        expect_v("flush_reg_write", C_SEL_RW, 32'd0);
        expect_v("flush_mem_write", C_SEL_MW, 32'd0);
        expect_v("flush_alu_op", C_SEL_OP, 32'd0);
        expect_v("flush_alu_a", C_SEL_A, 32'd0);
        fire();

        // sw $5, 8($1) with rt forwarded from MEM/WB; EX/MEM on rt also tested
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        load_id(32'h40, 32'h77, 32'd8, 5'd1, 5'd5, 5'd0, 3'b010, 5'b10001, 1'b0);
        fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
        tick();
        expect_v("sw_alu_b_imm", C_SEL_B, 32'd8);
        expect_v("sw_store_fwd", C_SEL_SD, 32'h55);
        expect_v("sw_alu_a", C_SEL_A, 32'h40);
        expect_v("sw_mem_write", C_SEL_MW, 32'd1);
        fire();
        exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'hABCD;
        #1;
        expect_v("sw_store_exm_wins", C_SEL_SD, 32'hABCD);
        fire();
        rst = 1'b1;
        #1;
        expect_v("async_reset_zero", C_SEL_ALLZ, 32'd0);
        fire();

        // First clock after reset release captures normally
        @(negedge clk);
        rst = 1'b0;
        load_id(32'hA, 32'hB, 32'd0, 5'd1, 5'd2, 5'd3, 3'b001, 5'b01100, 1'b0);
        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        expect_v("post_reset_alu_a", C_SEL_A, 32'hA);
        expect_v("post_reset_alu_b", C_SEL_B, 32'hB);
        expect_v("post_reset_alu_op", C_SEL_OP, 32'd1);
        fire();

        for (int i = 0; i < 10 && q.size() > 0; i++) #1;
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
